axis2lbus_tx: RTL and testbench

AXIS2LBUS_TX -- requirements
Module: axis2lbus_tx

---
 rtl/lbus_pkg.sv | 32 +++
 rtl/lbus_seg_pack.sv | 50 +++++
 rtl/axis2lbus_tx.sv | 157 +++++++++++++++
 tb/tb_axis2lbus_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbus_pkg.sv
// Shared LBUS TX definitions: segment geometry, TX FSM states, per-segment
// record and a byte-count helper for contiguous strobes.
package lbus_pkg;

  localparam int C_TRANSMISSION_SEGMENTS = 4;
  localparam int C_SEG_W                 = 128;
  localparam int C_SEG_BYTES             = C_SEG_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    FLUSH = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [C_SEG_W-1:0] data;
    logic               en;
    logic               sop;
    logic               eop;
    logic               err;
    logic [3:0]         mty;
  } lbus_seg_t;

  // Number of valid bytes in one segment's strobe slice.
  function automatic logic [4:0] cnt_bytes(input logic [C_SEG_BYTES-1:0] strb);
    logic [4:0] c;
    c = '0;
    for (int k = 0; k < C_SEG_BYTES; k++) c = c + {4'd0, strb[k]};
    return c;
  endfunction

endpackage

// File: rtl/lbus_seg_pack.sv
// One LBUS segment: byte swap, valid-byte count, eop/mty generation.
// force_err builds the error segment used for an empty tlast beat.
module lbus_seg_pack
  import lbus_pkg::*;
#(
  parameter int BYTE_SWAP = 1
) (
  input  logic [C_SEG_W-1:0]     data,
  input  logic [C_SEG_BYTES-1:0] strb,
  input  logic                   last,
  input  logic                   nxt_en,
  input  logic                   sop,
  input  logic                   force_err,
  output lbus_seg_t              seg,
  output logic [4:0]             cnt
);

  logic [C_SEG_W-1:0] data_sw;
  logic [4:0]         mty_w;
  logic               en_v;

  // AXIS byte 0 lands in the top byte of the segment when swapping
  always_comb begin
    data_sw = '0;
    for (int j = 0; j < C_SEG_BYTES; j++)
      data_sw[8*j +: 8] = (BYTE_SWAP != 0) ? data[C_SEG_W-8-8*j +: 8] : data[8*j +: 8];
  end

  assign cnt   = cnt_bytes(strb);
  assign en_v  = |strb;
  assign mty_w = 5'd16 - cnt;

  // Segment record; eop sits on the last enabled segment of a tlast beat
  always_comb begin
    seg = '0;
    if (force_err) begin
      seg.en  = 1'b1;
      seg.sop = sop;
      seg.eop = 1'b1;
      seg.err = 1'b1;
    end else if (en_v) begin
      seg.data = data_sw;
      seg.en   = 1'b1;
      seg.sop  = sop;
      seg.eop  = last & ~nxt_en;
      seg.mty  = (last & ~nxt_en) ? mty_w[3:0] : 4'd0;
    end
  end

endmodule

// File: rtl/axis2lbus_tx.sv
// AXI4-Stream (512b) to CMAC LBUS TX adapter, one registered stage.
// Optional statistics counters: define AXIS2LBUS_TX_STATS_EN.
module axis2lbus_tx
  import lbus_pkg::*;
#(
  parameter int TDATA_WIDTH = 512,  // only 512 is supported
  parameter int BYTE_SWAP   = 1
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tstrb,
  output logic [127:0]             lbus_data0,
  output logic [127:0]             lbus_data1,
  output logic [127:0]             lbus_data2,
  output logic [127:0]             lbus_data3,
  output logic [3:0]               lbus_en,
  output logic [3:0]               lbus_sop,
  output logic [3:0]               lbus_eop,
  output logic [3:0]               lbus_err,
  output logic [3:0]               lbus_mty0,
  output logic [3:0]               lbus_mty1,
  output logic [3:0]               lbus_mty2,
  output logic [3:0]               lbus_mty3,
  input  logic                     lbus_rdy,
  input  logic                     lbus_ovf,
  input  logic                     lbus_unf,
  output logic                     err_ovf,
  output logic                     err_unf
`ifdef AXIS2LBUS_TX_STATS_EN
  ,
  output logic [31:0]              stat_pkts,
  output logic [47:0]              stat_bytes,
  output logic [15:0]              stat_ovf
`endif
);

  localparam int NSEG = C_TRANSMISSION_SEGMENTS;

  tx_state_e                state, state_n;
  logic                     rdy_q, accept, emit, empty, empty_last;
  logic [NSEG:0]            seg_en;
  lbus_seg_t [NSEG-1:0]     seg_n, seg_q;
  logic [NSEG-1:0][4:0]     seg_cnt;

  assign accept     = s_axis_tvalid & s_axis_tready;
  assign empty      = ~|s_axis_tstrb;
  assign empty_last = empty & s_axis_tlast;
  // an empty non-last beat produces nothing and leaves the FSM alone
  assign emit       = accept & (~empty | s_axis_tlast);
  assign seg_en[NSEG] = 1'b0;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign seg_en[g] = |s_axis_tstrb[g*C_SEG_BYTES +: C_SEG_BYTES];
    lbus_seg_pack #(.BYTE_SWAP(BYTE_SWAP)) u_seg (
      .data      (s_axis_tdata[g*C_SEG_W +: C_SEG_W]),
      .strb      (s_axis_tstrb[g*C_SEG_BYTES +: C_SEG_BYTES]),
      .last      (s_axis_tlast),
      .nxt_en    (seg_en[g+1]),
      .sop       ((g == 0) && (state == IDLE)),
      .force_err ((g == 0) && empty_last),
      .seg       (seg_n[g]),
      .cnt       (seg_cnt[g])
    );
    assign lbus_en[g]  = seg_q[g].en;
    assign lbus_sop[g] = seg_q[g].sop;
    assign lbus_eop[g] = seg_q[g].eop;
    assign lbus_err[g] = seg_q[g].err;
  end

  assign lbus_data0 = seg_q[0].data;
  assign lbus_data1 = seg_q[1].data;
  assign lbus_data2 = seg_q[2].data;
  assign lbus_data3 = seg_q[3].data;
  assign lbus_mty0  = seg_q[0].mty;
  assign lbus_mty1  = seg_q[1].mty;
  assign lbus_mty2  = seg_q[2].mty;
  assign lbus_mty3  = seg_q[3].mty;

  // FSM state register
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) state <= IDLE;
    else             state <= state_n;
  end

  // FSM next state; overflow wins from any state and is left only by reset
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && !empty && !s_axis_tlast) state_n = PKT;
      PKT:     if (accept && s_axis_tlast)            state_n = IDLE;
      FLUSH:   state_n = FLUSH;
      default: state_n = IDLE;
    endcase
    if (lbus_ovf) state_n = FLUSH;
  end

  // FSM output: backpressure follows lbus_rdy one cycle late
  always_comb s_axis_tready = rdy_q && (state != FLUSH);

  // Output segments, ready pipeline and sticky error flags
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      rdy_q   <= 1'b0;
      seg_q   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      rdy_q <= lbus_rdy;
      seg_q <= emit ? seg_n : '0;
      if (lbus_ovf) err_ovf <= 1'b1;
      if (lbus_unf) err_unf <= 1'b1;
    end
  end

`ifdef AXIS2LBUS_TX_STATS_EN
  logic        ovf_q;
  logic [47:0] pkt_acc;
  logic [6:0]  beat_bytes;

  // valid bytes carried by the current beat
  always_comb begin
    beat_bytes = '0;
    for (int k = 0; k < NSEG; k++) beat_bytes = beat_bytes + {2'b0, seg_cnt[k]};
  end

  // Bytes are committed only when the packet's eop goes out
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      ovf_q      <= 1'b0;
      pkt_acc    <= '0;
      stat_pkts  <= '0;
      stat_bytes <= '0;
      stat_ovf   <= '0;
    end else begin
      ovf_q <= lbus_ovf;
      if (lbus_ovf && !ovf_q) stat_ovf <= stat_ovf + 16'd1;
      if (emit) begin
        if (s_axis_tlast) begin
          stat_pkts  <= stat_pkts + 32'd1;
          stat_bytes <= stat_bytes + pkt_acc + {41'd0, beat_bytes};
          pkt_acc    <= '0;
        end else begin
          pkt_acc    <= pkt_acc + {41'd0, beat_bytes};
        end
      end
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^seg_cnt;
`endif

endmodule

// File: tb/tb_axis2lbus_tx.sv
// Scoreboard bench for axis2lbus_tx: driver pushes expected LBUS beats,
// a monitor thread pops and compares whenever lbus_en is non-zero.
module tb_axis2lbus_tx;

  logic         user_clk = 1'b0;
  logic         user_rst_n;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tstrb;
  logic [127:0] lbus_data0, lbus_data1, lbus_data2, lbus_data3;
  logic [3:0]   lbus_en, lbus_sop, lbus_eop, lbus_err;
  logic [3:0]   lbus_mty0, lbus_mty1, lbus_mty2, lbus_mty3;
  logic         lbus_rdy, lbus_ovf, lbus_unf, err_ovf, err_unf;
`ifdef AXIS2LBUS_TX_STATS_EN
  logic [31:0]  stat_pkts;
  logic [47:0]  stat_bytes;
  logic [15:0]  stat_ovf;
`endif

  always #5 user_clk = ~user_clk;

  axis2lbus_tx #(.TDATA_WIDTH(512), .BYTE_SWAP(1)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
    .lbus_data0(lbus_data0), .lbus_data1(lbus_data1), .lbus_data2(lbus_data2), .lbus_data3(lbus_data3),
    .lbus_en(lbus_en), .lbus_sop(lbus_sop), .lbus_eop(lbus_eop), .lbus_err(lbus_err),
    .lbus_mty0(lbus_mty0), .lbus_mty1(lbus_mty1), .lbus_mty2(lbus_mty2), .lbus_mty3(lbus_mty3),
    .lbus_rdy(lbus_rdy), .lbus_ovf(lbus_ovf), .lbus_unf(lbus_unf),
    .err_ovf(err_ovf), .err_unf(err_unf)
`ifdef AXIS2LBUS_TX_STATS_EN
    , .stat_pkts(stat_pkts), .stat_bytes(stat_bytes), .stat_ovf(stat_ovf)
`endif
  );

  typedef struct {
    logic [3:0]   en, sop, eop, err;
    logic [15:0]  mty;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] ALL = {64{1'b1}};

  function automatic logic [511:0] pat(input logic [7:0] s);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = s + 8'(k);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every cycle with segments out must match the oldest expectation
  task automatic monitor();
    exp_t         e;
    logic [511:0] dat;
    logic [15:0]  mty;
    bit           bad;
    forever begin
      @(negedge user_clk);
      if (user_rst_n && lbus_en != 4'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: en=%b sop=%b eop=%b with no beat expected", lbus_en, lbus_sop, lbus_eop);
        end else begin
          e   = exp_q.pop_front();
          mty = {lbus_mty3, lbus_mty2, lbus_mty1, lbus_mty0};
          dat = {lbus_data3, lbus_data2, lbus_data1, lbus_data0};
          if ({lbus_en, lbus_sop, lbus_eop, lbus_err, mty} !== {e.en, e.sop, e.eop, e.err, e.mty}) begin
            errors++;
            $display("FAIL beat_ctrl: got en=%b sop=%b eop=%b err=%b mty=%h expected en=%b sop=%b eop=%b err=%b mty=%h",
                     lbus_en, lbus_sop, lbus_eop, lbus_err, mty, e.en, e.sop, e.eop, e.err, e.mty);
          end
          bad = 1'b0;
          for (int i = 0; i < 4; i++)
            if (e.en[i] && !e.err[i])
              for (int j = 0; j < 16; j++)
                if (dat[128*i + 127 - 8*j -: 8] !== e.data[8*(16*i + j) +: 8]) bad = 1'b1;
          checks++;
          if (bad) begin
            errors++;
            $display("FAIL beat_data: got %h expected swapped bytes of %h", dat, e.data);
          end
        end
      end
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record expected output
  task automatic send(input logic [511:0] d, input logic [63:0] strb, input logic last, input bit want,
                      input logic [3:0] en, input logic [3:0] sop, input logic [3:0] eop,
                      input logic [3:0] err, input logic [15:0] mty);
    int   n;
    exp_t e;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tstrb = strb; s_axis_tlast = last;
    n = 0;
    while (!s_axis_tready && n < 50) begin
      @(posedge user_clk); @(negedge user_clk); n++;
    end
    checks++;
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL tready_wait: tready=%b after %0d cycles, expected 1", s_axis_tready, n);
    end else begin
      if (want) begin
        e.en = en; e.sop = sop; e.eop = eop; e.err = err; e.mty = mty; e.data = d;
        exp_q.push_back(e);
      end
      @(posedge user_clk); @(negedge user_clk);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tstrb = '0;
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_rst_n = 1'b0;
    repeat (2) @(negedge user_clk);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_en_sop_eop_err", {lbus_en, lbus_sop, lbus_eop, lbus_err}, 0);
    chk("rst_data_mty", {lbus_data0, lbus_mty0, lbus_mty3}, 0);
    chk("rst_err_flags", {err_ovf, err_unf}, 0);
`ifdef AXIS2LBUS_TX_STATS_EN
    chk("rst_stats", {stat_pkts, stat_bytes, stat_ovf}, 0);
`endif
    user_rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    user_rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tstrb = '0;
    lbus_rdy = 1'b1; lbus_ovf = 1'b0; lbus_unf = 1'b0;
    fork monitor(); join_none
    do_reset();

    // 64B single beat
    send(pat(8'h00), ALL, 1, 1, 4'b1111, 4'b0001, 4'b1000, 4'b0000, 16'h0000);
    @(negedge user_clk);
    chk("idle_zero", {lbus_en, lbus_sop, lbus_eop, lbus_data0, lbus_mty3}, 0);

    // 65B: second beat carries one byte
    send(pat(8'h10), ALL,   0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    send(pat(8'h20), 64'h1, 1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h000F);

    // 100B: 36 bytes in last beat -> segment 2 holds 4 bytes
    send(pat(8'h30), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    send(pat(8'h40), 64'h0000_000F_FFFF_FFFF, 1, 1, 4'b0111, 4'b0000, 4'b0100, 4'b0000, 16'h0C00);

    // lbus_rdy low three cycles mid-packet while beats keep coming
    send(pat(8'h50), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    fork
      begin
        send(pat(8'h51), ALL, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
        send(pat(8'h52), ALL, 0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
        send(pat(8'h53), 64'hFFFF_FFFF, 1, 1, 4'b0011, 4'b0000, 4'b0010, 4'b0000, 16'h0000);
      end
      begin
        lbus_rdy = 1'b0;
        chk("stall_t0", s_axis_tready, 1);
        @(negedge user_clk); chk("stall_t1", s_axis_tready, 0);
        @(negedge user_clk); chk("stall_t2", s_axis_tready, 0);
        @(negedge user_clk); lbus_rdy = 1'b1; chk("stall_t3", s_axis_tready, 0);
        @(negedge user_clk); chk("stall_t4", s_axis_tready, 1);
      end
    join

    // underflow mid-packet: sticky flag, packet continues without new sop
    send(pat(8'h60), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    lbus_unf = 1'b1;
    @(negedge user_clk); lbus_unf = 1'b0;
    chk("err_unf_set", err_unf, 1);
    @(negedge user_clk);
    chk("err_unf_sticky", err_unf, 1);
    send(pat(8'h61), 64'hFFFF, 1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0000);

    // empty tlast beat mid-packet -> error segment, then a fresh packet
    send(pat(8'h70), ALL,   0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    send(pat(8'h71), 64'h0, 1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 16'h0000);
    send(pat(8'h72), ALL,   1, 1, 4'b1111, 4'b0001, 4'b1000, 4'b0000, 16'h0000);

    // empty non-last beat: nothing emitted, state held
    send(pat(8'h80), ALL,   0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    send(pat(8'h81), 64'h0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    chk("empty_beat_no_out", lbus_en, 0);
    send(pat(8'h82), 64'hFFFF, 1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 16'h0000);
    send(pat(8'h83), 64'h0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000);
    send(pat(8'h84), ALL,   1, 1, 4'b1111, 4'b0001, 4'b1000, 4'b0000, 16'h0000);

    // reset mid-packet: next beat starts a new packet
    send(pat(8'h90), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    do_reset();
    send(pat(8'h91), 64'hFFFF_FFFF, 1, 1, 4'b0011, 4'b0001, 4'b0010, 4'b0000, 16'h0000);

    // overflow: flush until reset
    send(pat(8'hA0), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
    lbus_ovf = 1'b1;
    @(negedge user_clk); lbus_ovf = 1'b0;
    chk("err_ovf_set", err_ovf, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = pat(8'hA1); s_axis_tstrb = ALL; s_axis_tlast = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("flush_tready", s_axis_tready, 0);
      @(negedge user_clk);
      chk("flush_en", lbus_en, 0);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tstrb = '0;
`ifdef AXIS2LBUS_TX_STATS_EN
    chk("stat_ovf", stat_ovf, 1);
`endif
    do_reset();

    // ten 100B packets after recovery
    for (int p = 0; p < 10; p++) begin
      send(pat(8'(p * 3)), ALL, 0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 16'h0000);
      send(pat(8'(p * 5)), 64'h0000_000F_FFFF_FFFF, 1, 1, 4'b0111, 4'b0000, 4'b0100, 4'b0000, 16'h0C00);
    end
    @(negedge user_clk);
`ifdef AXIS2LBUS_TX_STATS_EN
    chk("stat_pkts", stat_pkts, 10);
    chk("stat_bytes", stat_bytes, 1000);
`endif

    repeat (3) @(negedge user_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
